// File: rtl/iob_bus_pkg.sv
// iob_bus_pkg: shared request/response layout, FSM encoding and defaults for iob_bus_guard.
// Rev 1.0
`default_nettype none

package iob_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  // Request layout, MSB to LSB: valid, address, wdata, wstrb.
  localparam int WSTRB_LSB = 0;
  // Response layout, MSB to LSB: rdata, ready.
  localparam int READY_POS = 0;
  localparam int RDATA_LSB = 1;

  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int wdata_lsb(input int dw);
    return dw / 8;
  endfunction

  function automatic int addr_lsb(input int dw);
    return dw + dw / 8;
  endfunction

  function automatic int valid_pos(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_bus_guard_timer.sv
// iob_bus_guard_timer: clearable up-counter with enable and terminal count at TIMEOUT-1.
// Rev 1.0
`default_nettype none

module iob_bus_guard_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tc = (r_cnt == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/iob_bus_guard.sv
// iob_bus_guard: registered CPU-to-memory request stage with one pending slot and response timeout.
// Rev 1.0
`default_nettype none

module iob_bus_guard
  import iob_bus_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [req_w(ADDR_W, DATA_W)-1:0]  s_req,
  output logic [resp_w(DATA_W)-1:0]         s_resp,
  output logic [req_w(ADDR_W, DATA_W)-1:0]  m_req,
  input  logic [resp_w(DATA_W)-1:0]         m_resp,
  input  logic                              err_clr,
  output logic                              err,
  output logic [ADDR_W-1:0]                 err_addr,
  output logic                              ovf
);

  localparam int VALID_POS = valid_pos(ADDR_W, DATA_W);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
  } req_t;

  state_e              r_state;
  req_t                r_act;
  req_t                r_pend;
  logic                r_pend_valid;
  logic                r_s_ready;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [ADDR_W-1:0]   r_err_addr;
  logic                r_ovf;

  req_t                w_s;
  logic                w_s_valid;
  logic                w_m_ready;
  logic [DATA_W-1:0]   w_m_rdata;
  logic                w_busy;
  logic                w_tc;
  logic                w_done;
  logic                w_tout;
  logic                w_fin;
  logic                w_drop;

  assign w_s       = s_req[VALID_POS-1:0];
  assign w_s_valid = s_req[VALID_POS];
  assign w_m_ready = m_resp[READY_POS];
  assign w_m_rdata = m_resp[RDATA_LSB +: DATA_W];

  assign w_busy = (r_state == BUSY);
  // A real answer on the terminal cycle beats the timeout.
  assign w_done = w_busy && w_m_ready;
  assign w_tout = w_busy && !w_m_ready && w_tc;
  assign w_fin  = w_done || w_tout;
  assign w_drop = w_busy && !w_fin && w_s_valid && r_pend_valid;

  iob_bus_guard_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (!w_busy || w_fin),
    .en  (w_busy),
    .tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_act        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_s_ready    <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_err_addr   <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_s_ready <= w_fin;
      r_rdata   <= w_done ? w_m_rdata : (w_tout ? ERR_DATA : '0);

      case (r_state)
        IDLE: begin
          if (w_s_valid) begin
            r_act   <= w_s;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_fin) begin
            // Reissue with no gap; a pulse arriving now takes the freed slot.
            if (r_pend_valid) begin
              r_act        <= r_pend;
              r_pend_valid <= w_s_valid;
              if (w_s_valid) r_pend <= w_s;
            end else if (w_s_valid) begin
              r_act <= w_s;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_s_valid && !r_pend_valid) begin
            r_pend       <= w_s;
            r_pend_valid <= 1'b1;
          end
        end
      endcase

      if (w_tout) begin
        r_err <= 1'b1;
        if (!r_err) r_err_addr <= r_act.addr;
      end else if (err_clr) begin
        r_err      <= 1'b0;
        r_err_addr <= '0;
      end

      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (err_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign m_req    = {w_busy, r_act};
  assign s_resp   = {r_rdata, r_s_ready};
  assign err      = r_err;
  assign err_addr = r_err_addr;
  assign ovf      = r_ovf;

endmodule

`default_nettype wire
